// File: rtl/apb_master.sv
// APB initiator: queues local commands in a small FIFO and replays them as
// APB transfers toward an 8-bit register slave. The slave has no pready,
// so the access phase lasts a fixed ACCESS_CYCLES cycles.
module apb_master #(
    parameter int DEPTH         = 4,
    parameter int ACCESS_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic [7:0] addr,
    output logic [7:0] pwdata,
    output logic       pwrite,
    output logic       psel,
    output logic       penable,
    input  logic [7:0] prdata,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
    localparam logic [CW-1:0] COUNT_ZERO = CW'(0);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);
    localparam logic [3:0]    ACC_LOAD   = 4'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    // FIFO entry layout: {write, addr[7:0], wdata[7:0]}
    logic [16:0]   fifo_mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    state_t        state_r;
    state_t        state_s;
    logic [3:0]    wait_cnt_r;
    logic          push_s;
    logic          pop_s;
    logic          complete_s;
    logic          not_empty_s;
    logic [16:0]   head_s;

    // Status outputs depend only on registered state: no bypass when full.
    assign cmd_ready   = (count_r < FULL_COUNT);
    assign not_empty_s = (count_r != COUNT_ZERO);
    assign busy        = not_empty_s || (state_r != ST_IDLE);
    assign push_s      = cmd_valid && cmd_ready;
    assign head_s      = fifo_mem_r[rd_ptr_r];

    // FIFO storage; validity is tracked by the pointers and count, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= {cmd_write, cmd_addr, cmd_wdata};
        end
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + COUNT_ONE;
                2'b01:   count_r <= count_r - COUNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Next-state logic: pop on leaving IDLE or on completing with work queued.
    always_comb begin
        state_s    = state_r;
        pop_s      = 1'b0;
        complete_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (not_empty_s) begin
                    pop_s   = 1'b1;
                    state_s = ST_SETUP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_s = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (wait_cnt_r != 4'd0) begin
                    state_s = ST_ACCESS;
                end else begin
                    complete_s = 1'b1;
                    if (not_empty_s) begin
                        pop_s   = 1'b1;
                        state_s = ST_SETUP;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register, access-phase wait counter and registered APB strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= 4'd0;
            psel       <= 1'b0;
            penable    <= 1'b0;
        end else begin
            state_r <= state_s;
            psel    <= (state_s != ST_IDLE);
            penable <= (state_s == ST_ACCESS);
            if (state_r == ST_SETUP) begin
                wait_cnt_r <= ACC_LOAD;
            end else if ((state_r == ST_ACCESS) && (wait_cnt_r != 4'd0)) begin
                wait_cnt_r <= wait_cnt_r - 4'd1;
            end
        end
    end

    // Address/data/direction change only when a command is popped.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr   <= 8'd0;
            pwdata <= 8'd0;
            pwrite <= 1'b0;
        end else if (pop_s) begin
            pwrite <= head_s[16];
            addr   <= head_s[15:8];
            pwdata <= head_s[7:0];
        end
    end

    // Read capture: one-cycle strobe after a completing read transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= 8'd0;
        end else begin
            rd_valid <= complete_s && !pwrite;
            if (complete_s && !pwrite) begin
                rd_data <= prdata;
            end
        end
    end

endmodule

// File: doc/apb_master.md
# apb_master

APB initiator that turns a local command stream into APB transfers toward the existing 8-bit `apb_modul` register slave. Commands enter a small FIFO, and an IDLE/SETUP/ACCESS state machine drives `psel`/`penable`/`pwrite`/`addr`/`pwdata`. Read data is captured from `prdata` and returned on a one-cycle strobe. The slave has no `pready`, so the access phase has a fixed, parameterised length.

## Interface
- `DEPTH`, 4, command FIFO depth; a power of 2, from 2 to 16.
- `ACCESS_CYCLES`, 1, number of cycles `penable` stays high per transfer; 1..16.
- `clk`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  FIFO can accept; equals `count < DEPTH`.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  8  target register address.
- `cmd_wdata`  in  8  write data; ignored for reads.
- `addr`  out  8  APB address.
- `pwdata`  out  8  APB write data.
- `pwrite`  out  1  APB direction.
- `psel`  out  1  APB select.
- `penable`  out  1  APB enable.
- `prdata`  in  8  APB read data from the slave.
- `rd_valid`  out  1  one-cycle pulse: `rd_data` holds a completed read.
- `rd_data`  out  8  captured read data.
- `busy`  out  1  1 when the FIFO is non-empty or the state is not IDLE.

## Operation
- **Command push:** a command is pushed when `cmd_valid && cmd_ready` at a clock edge.
  - The FIFO stores {write, addr, wdata} in 17 bits.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - `count` is log2(DEPTH)+1 bits.
- **State IDLE:** `psel`=0, `penable`=0.
  - If the FIFO is non-empty: pop the head, load `addr`/`pwdata`/`pwrite`, and go to SETUP.
- **State SETUP:** `psel`=1, `penable`=0. Unconditionally go to ACCESS and load the wait counter with ACCESS_CYCLES-1.
- **State ACCESS:** `psel`=1, `penable`=1.
  - While the counter is non-zero, decrement it and stay in ACCESS.
  - When the counter is zero, the transfer completes at this edge:
    - For a read: `rd_data` <= `prdata` and `rd_valid` <= 1.
    - Then, if the FIFO is non-empty: pop and go to SETUP back-to-back, with no IDLE cycle. Otherwise go to IDLE.
- **Output holding:** `addr`/`pwdata`/`pwrite` change only on a pop.
  - They are stable from SETUP through the end of ACCESS.
  - In IDLE they keep their last values.
- `pwdata` is loaded on reads too (with the stored `cmd_wdata`), but it has no meaning on reads.
- **Simultaneous push and pop:** `count` is unchanged and both pointers advance.
- **Full FIFO:** `cmd_ready`=0 even if a pop happens in the same cycle; there is no bypass.
- **Empty FIFO:** a pop is never attempted.
- **Reset:** clears the FIFO, pointers, count, state (to IDLE) and counter.
  - Reset asserted mid-transfer aborts it: `psel`/`penable` are 0 in the cycle after the reset edge.
  - Any pending `rd_valid` is suppressed.
  - Queued commands are discarded.

## Timing
- **Reset values:** `addr`=0, `pwdata`=0, `pwrite`=0, `psel`=0, `penable`=0, `rd_valid`=0, `rd_data`=0, `cmd_ready`=1, `busy`=0.
- All outputs are registered except `cmd_ready` and `busy`. Those two are combinational from registered state only, with no input-to-output paths.
- **Latency from an idle block** (command pushed at edge k):
  - SETUP is visible after edge k+1.
  - ACCESS is visible after edge k+2 and lasts ACCESS_CYCLES cycles.
  - Completion is at edge k+2+ACCESS_CYCLES.
  - `rd_valid` is high for exactly the cycle after completion.
- **Throughput:** back-to-back transfers take 1+ACCESS_CYCLES cycles each. `psel` stays high continuously across consecutive queued transfers.
- `penable` never rises without `psel` having been high for the preceding cycle.

## Test plan
- **Reset:** assert `reset` for 3 cycles, then release. -> All outputs hold the reset values above; `cmd_ready`=1, `busy`=0.
- **Single write:** push write addr=6, wdata=4, with ACCESS_CYCLES=1. -> `psel`=1 one edge later; `penable`=1 the next; `addr`=6, `pwdata`=4, `pwrite`=1 throughout; back to IDLE; `rd_valid` never asserts.
- **Read-back:** push read addr=6 with the slave holding 4. -> `pwrite`=0; `rd_valid` pulses once with `rd_data`=4, in the cycle after the ACCESS edge.
- **Burst and full FIFO:** push 5 commands with DEPTH=4 while the FSM is stalled by ACCESS_CYCLES=3.
  - `cmd_ready` drops to 0 after the 4th accepted push. The 5th is accepted only after a pop.
  - Transfers occur in push order with `psel` continuously high.
  - Each transfer takes 4 cycles.
- **Simultaneous push/pop:** push at the same edge as a pop. -> `count` is unchanged and no command is lost or duplicated. Verify this with a scoreboard across a pointer wrap (at least 10 commands).
- **Mid-transfer reset:** assert `reset` during ACCESS of a read with 2 commands queued. -> Next cycle `psel`=0, `penable`=0, no `rd_valid`; after release `busy`=0 and no queued transfer executes.
